fsm_seq_gen: RTL and testbench
==============================

// Module: fsm_seq_gen
// PURPOSE
//  Serial bit-stream transmitter; the driving end of the serial `in` line consumed by our 3-state sequence detector.
//  Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per clk.
//  Idle gap cycles follow each word. Exposes state/next_state for debug, like the detector.
// PARAMETERS
//  WIDTH  8  data bits per word (>=2)
//  GAP    2  idle cycles after each word (0 allowed)
// PORTS
//  clk         in   1      single clock, rising edge
//  reset_n     in   1      asynchronous, active-low reset
//  load_valid  in   1      load_data is valid
//  load_data   in   WIDTH  word to transmit
//  load_ready  out  1      block can accept a word (combinational: state==IDLE)
//  out         out  1      serial bit, registered
//  out_valid   out  1      out carries a data/parity bit, registered
//  done        out  1      one-cycle pulse after last bit of a word, registered
//  state       out  2      current state
//  next_state  out  2      combinational next state
// BEHAVIOUR
//  Reset (reset_n=0, takes effect immediately): state=IDLE, out=0, out_valid=0, done=0, counters=0. load_ready=1.
//  States: IDLE=2'b00, SHIFT=2'b01, GAP=2'b10; 2'b11 is illegal -> next_state=IDLE.
//  IDLE: transfer = load_valid & load_ready. On the transfer edge: shreg<=load_data, bit_cnt<=0, state<=SHIFT.
//  SHIFT: out=shreg[WIDTH-1], out_valid=1. Each clk: shift left by 1, bit_cnt++.
//   The first bit appears in the cycle after the transfer edge, so latency is 1 clk.
//   After the last bit (bit_cnt==NBITS-1): state->GAP if GAP>0, else ->IDLE. done=1 for exactly the next cycle.
//  GAP: out=0, out_valid=0. gap_cnt counts GAP cycles, then state->IDLE.
//  load_valid while load_ready=0: ignored, data not captured. The source holds valid/data until ready.
//  Back-to-back with valid held: accept period = NBITS+GAP+1 clks (one IDLE cycle minimum).
//  Counter widths: $clog2(WIDTH+1) and $clog2(GAP+1). No wrap is possible; counters clear on state entry.
//  reset_n asserted mid-word: word discarded; outputs take reset values asynchronously.
//   After release, the next accepted word starts cleanly from bit WIDTH-1.
//  out=0 whenever out_valid=0.
// CONFIGURATION
//  SEQ_GEN_PARITY_EN defined: NBITS=WIDTH+1. After the data bits, one even-parity bit (^load_data captured at load)
//   is sent with out_valid=1. done follows the parity bit.
//  Undefined: NBITS=WIDTH, no parity bit, no parity register.
// STRUCTURE
//  Shared include fsm_defs.vh: state encodings IDLE/SHIFT/GAP as localparams, shared with the detector.
//  One natural sub-module: fsm_seq_shreg (parallel-load shift register + bit counter, asserts last_bit).
//  FSM, gap counter and output registers stay in fsm_seq_gen.
// TESTING  (WIDTH=8, GAP=2)
//  1. reset_n=0 for 2 clks -> state=00, out=0, out_valid=0, done=0, load_ready=1.
//  2. Load 8'hA5 -> out=1,0,1,0,0,1,0,1 on 8 consecutive clks with out_valid=1. Then done pulse,
//     2 cycles out_valid=0, IDLE.
//  3. During 2nd bit of 8'hA5, drive load_valid=1 with 8'hFF -> load_ready=0, 8'hFF not captured,
//     A5 stream unchanged, FF sent after return to IDLE.
//  4. load_valid held with 8'h01 then 8'h80 -> transfers exactly 11 clks apart;
//     out=00000001 then 10000000.
//  5. reset_n low after 3 bits of 8'hC3 -> out/out_valid/state go to 0 immediately.
//     After release, load 8'h3C streams 00111100 cleanly.
//  6. SEQ_GEN_PARITY_EN: 8'hA5 -> 9th bit 0; 8'h07 -> 9th bit 1.
//     done is asserted after bit 9; period is 12 clks.

Source files
------------

// File: rtl/fsm_seq_gen_pkg.sv
// Shared state encodings and sizing helpers for the serial sequence generator.
package fsm_seq_gen_pkg;

    // Encodings match the downstream sequence detector's debug view.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Width of a counter that must hold 0..n; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/fsm_seq_gen_shreg.sv
// Parallel-load, MSB-first shift register with a bit counter that flags the last bit.
module fsm_seq_shreg #(
    parameter int NBITS = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [NBITS-1:0] data_i,
    output logic             msb_next_o,
    output logic             last_bit_o
);
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    assign last_bit_o = (bit_cnt_q == CNT_W'(NBITS - 1));
    // The bit that will be on the line next cycle, so the owner can register it.
    assign msb_next_o = shreg_d[NBITS-1];

    always_comb begin
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (load_i) begin
            shreg_d   = data_i;
            bit_cnt_d = '0;
        end else if (shift_i) begin
            shreg_d = {shreg_q[NBITS-2:0], 1'b0};
            if (!last_bit_o) bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/fsm_seq_gen.sv
// Serial MSB-first word transmitter with idle gap; SEQ_GEN_PARITY_EN appends an even-parity bit.
module fsm_seq_gen
    import fsm_seq_gen_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             out,
    output logic             out_valid,
    output logic             done,
    output logic [1:0]       state,
    output logic [1:0]       next_state
);
`ifdef SEQ_GEN_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int CNT_W = cnt_w(WIDTH);
    localparam int GAP_W = cnt_w(GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t             state_q, state_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               out_q, out_d, out_valid_q, out_valid_d, done_q, done_d;
    logic               xfer, shift, msb_next, last_bit;
    logic [NBITS-1:0]   load_word;

`ifdef SEQ_GEN_PARITY_EN
    // Parity rides in the shift register's LSB so it falls out after the data.
    assign load_word = {load_data, ^load_data};
`else
    assign load_word = load_data;
`endif

    assign xfer  = (state_q == ST_IDLE) && load_valid;
    assign shift = (state_q == ST_SHIFT);

    fsm_seq_shreg #(.NBITS(NBITS), .CNT_W(CNT_W)) u_shreg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (xfer),
        .shift_i    (shift),
        .data_i     (load_word),
        .msb_next_o (msb_next),
        .last_bit_o (last_bit)
    );

    always_comb begin
        state_d     = state_q;
        gap_cnt_d   = gap_cnt_q;
        out_d       = 1'b0;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d     = ST_SHIFT;
                    out_d       = msb_next;
                    out_valid_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP > 0) ? ST_GAP : ST_IDLE;
                end else begin
                    out_d       = msb_next;
                    out_valid_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                       gap_cnt_d = gap_cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            gap_cnt_q   <= '0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign load_ready = (state_q == ST_IDLE);
    assign out        = out_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;
    assign state      = state_q;
    assign next_state = state_d;

endmodule

// File: tb/tb_fsm_seq_gen.sv
// Bench for fsm_seq_gen: fixed vector table, hand sequences and randomized traffic vs a timeline model.
module tb_fsm_seq_gen;
    localparam int W   = 8;
    localparam int GP  = 2;
`ifdef SEQ_GEN_PARITY_EN
    localparam int NB  = W + 1;
`else
    localparam int NB  = W;
`endif
    localparam int BIG = 1000;

    logic         clk = 1'b0;
    logic         reset_n, load_valid;
    logic [W-1:0] load_data;
    logic         load_ready, out, out_valid, done;
    logic [1:0]   state, next_state;

    int checks = 0, failures = 0, cyc = 0;
    int m_age = BIG;            // clocks since the model's last accepted word
    logic [W-1:0] m_word = '0;
    logic dut_xfer, pre_rdy;

    typedef struct {
        logic       lv;
        logic [7:0] d;
        logic       rdy;
        logic       o;
        logic       ov;
        logic       dn;
        logic [1:0] st;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fsm_seq_gen #(.WIDTH(W), .GAP(GP)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .out        (out),
        .out_valid  (out_valid),
        .done       (done),
        .state      (state),
        .next_state (next_state)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic seq_bit(input logic [W-1:0] d, input int i);
        if (i < W) return d[W-1-i];
        return ^d;
    endfunction

    function automatic logic [1:0] exp_state(input int a);
        if (a >= 1 && a <= NB)       return 2'b01;
        if (a > NB && a <= NB + GP)  return 2'b10;
        return 2'b00;
    endfunction

    // One clock: check handshake pre-edge, advance model, check registered outputs after edge.
    task automatic tick(input string tag);
        logic er, eo;
        #1;
        er = (m_age > NB + GP);
        pre_rdy = load_ready;
        chk({tag, ".ready"}, 32'(load_ready), 32'(er));
        dut_xfer = load_ready & load_valid;
        if (er && load_valid) begin
            m_word = load_data;
            m_age  = 1;
        end else if (m_age < BIG) m_age++;
        chk({tag, ".next_state"}, 32'(next_state), 32'(exp_state(m_age)));
        @(posedge clk); #1;
        cyc++;
        eo = (m_age >= 1 && m_age <= NB) ? seq_bit(m_word, m_age - 1) : 1'b0;
        chk({tag, ".out"},       32'(out),       32'(eo));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_age >= 1 && m_age <= NB));
        chk({tag, ".done"},      32'(done),      32'(m_age == NB + 1));
        chk({tag, ".state"},     32'(state),     32'(exp_state(m_age)));
    endtask

    // Asynchronous reset mid-cycle; outputs must clear without waiting for a clock.
    task automatic hit_reset(input string tag);
        #2;
        reset_n = 1'b0;
        m_age   = BIG;
        #1;
        chk({tag, ".rst_out"},   32'(out),        32'd0);
        chk({tag, ".rst_ov"},    32'(out_valid),  32'd0);
        chk({tag, ".rst_done"},  32'(done),       32'd0);
        chk({tag, ".rst_state"}, 32'(state),      32'd0);
        chk({tag, ".rst_ready"}, 32'(load_ready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    task automatic addv(input int lv, input int d, input int rdy, input int o,
                        input int ov, input int dn, input int st);
        vec_t e;
        e.lv = 1'(lv); e.d = 8'(d); e.rdy = 1'(rdy); e.o = 1'(o);
        e.ov = 1'(ov); e.dn = 1'(dn); e.st = 2'(st);
        tbl.push_back(e);
    endtask

    task automatic drain(input string tag);
        load_valid = 1'b0;
        for (int i = 0; i < NB + GP + 2; i++) tick(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, n;
        reset_n = 1'b0; load_valid = 1'b0; load_data = '0;

        // Reset held for two clocks.
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t1.state",     32'(state),      32'd0);
        chk("t1.out",       32'(out),        32'd0);
        chk("t1.out_valid", 32'(out_valid),  32'd0);
        chk("t1.done",      32'(done),       32'd0);
        chk("t1.ready",     32'(load_ready), 32'd1);
        reset_n = 1'b1;

        // 8'hA5 stream: 1,0,1,0,0,1,0,1 then done, gap, idle.
        addv(1, 8'hA5, 1, 1, 1, 0, 1);
        addv(0, 0, 0, 0, 1, 0, 1);
        addv(0, 0, 0, 1, 1, 0, 1);
        addv(0, 0, 0, 0, 1, 0, 1);
        addv(0, 0, 0, 0, 1, 0, 1);
        addv(0, 0, 0, 1, 1, 0, 1);
        addv(0, 0, 0, 0, 1, 0, 1);
        addv(0, 0, 0, 1, 1, 0, 1);
`ifdef SEQ_GEN_PARITY_EN
        addv(0, 0, 0, 0, 1, 0, 1);
`endif
        addv(0, 0, 0, 0, 0, 1, 2);
        addv(0, 0, 0, 0, 0, 0, 2);
        addv(0, 0, 0, 0, 0, 0, 0);
        addv(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            load_valid = tbl[i].lv;
            load_data  = tbl[i].d;
            tick($sformatf("t2[%0d]", i));
            chk($sformatf("t2v[%0d].ready", i), 32'(pre_rdy),   32'(tbl[i].rdy));
            chk($sformatf("t2v[%0d].out", i),   32'(out),       32'(tbl[i].o));
            chk($sformatf("t2v[%0d].ov", i),    32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("t2v[%0d].done", i),  32'(done),      32'(tbl[i].dn));
            chk($sformatf("t2v[%0d].state", i), 32'(state),     32'(tbl[i].st));
        end

        // Load offered while busy must wait for the next IDLE cycle.
        load_valid = 1'b1; load_data = 8'hA5;
        tick("t3");
        t1 = cyc;
        load_valid = 1'b0;
        tick("t3");
        load_valid = 1'b1; load_data = 8'hFF;
        t2 = -1;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            tick("t3");
            if (dut_xfer) begin
                t2 = cyc;
                load_valid = 1'b0;
            end
        end
        chk("t3.ff_accept_gap", 32'(t2 - t1), 32'(NB + GP + 1));
        drain("t3");

        // Valid held across two words: fixed accept period.
        load_valid = 1'b1; load_data = 8'h01;
        n = 0; t1 = 0; t2 = 0;
        for (int i = 0; i < 40 && n < 2; i++) begin
            tick("t4");
            if (dut_xfer) begin
                n++;
                if (n == 1) begin t1 = cyc; load_data = 8'h80; end
                else begin t2 = cyc; load_valid = 1'b0; end
            end
        end
        chk("t4.transfers", 32'(n), 32'd2);
        chk("t4.period", 32'(t2 - t1), 32'(NB + GP + 1));
        drain("t4");

        // Reset mid-word, then a clean restart.
        load_valid = 1'b1; load_data = 8'hC3;
        tick("t5");
        load_valid = 1'b0;
        tick("t5");
        tick("t5");
        hit_reset("t5");
        load_valid = 1'b1; load_data = 8'h3C;
        tick("t5b");
        drain("t5b");

`ifdef SEQ_GEN_PARITY_EN
        // Odd-weight word carries a 1 parity bit.
        load_valid = 1'b1; load_data = 8'h07;
        tick("t6");
        load_valid = 1'b0;
        for (int i = 0; i < W; i++) tick("t6");
        chk("t6.par07",    32'(out),       32'd1);
        chk("t6.par07_ov", 32'(out_valid), 32'd1);
        tick("t6");
        chk("t6.done", 32'(done), 32'd1);
        drain("t6");
`endif

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(63) == 0) begin
                load_valid = 1'b0;
                hit_reset("rnd");
            end else begin
                load_valid = 1'($urandom_range(1));
                load_data  = 8'($urandom);
                tick("rnd");
            end
        end
        drain("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
